uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requester ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: byte width, matches UART transmitter.
REQ-003 SHALL have parameter MAX_BEATS, default 256: longest allowed packet, in beats.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-006 SHALL have port s_axis_tdata  input  N*DATA_WIDTH  requester data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port s_axis_tvalid  input  N  per-port valid.
REQ-008 SHALL have port s_axis_tlast  input  N  per-port end-of-packet.
REQ-009 SHALL have port s_axis_tready  output  N  per-port ready.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  byte to the UART transmitter.
REQ-011 SHALL have port m_axis_tvalid  output  1  byte valid.
REQ-012 SHALL have port m_axis_tready  input  1  transmitter ready.
REQ-013 SHALL have port m_axis_tid  output  clog2(N)  index of the granted port.
REQ-014 SHALL have port grant  output  N  one-hot grant; all zero when idle.
REQ-015 SHALL have port busy  output  1  high while a packet is granted.
REQ-016 SHALL have port trunc_error  output  1  one-cycle pulse on forced release at MAX_BEATS.

Function
REQ-017 SHALL implement two states: IDLE and GRANT.
REQ-018 In IDLE, s_axis_tready SHALL be all zero and m_axis_tvalid SHALL be 0.
REQ-019 In IDLE with any tvalid high, the arbiter SHALL select the first valid port at or after index ptr, searching upward and wrapping modulo N.
REQ-020 The selected port's grant bit SHALL be registered, and the state SHALL become GRANT on the next cycle; arbitration latency is 1 cycle.
REQ-021 In GRANT, m_axis_tdata, m_axis_tvalid and m_axis_tid SHALL come combinationally from granted port g, with s_axis_tready[g] = m_axis_tready and all other ready bits 0.
REQ-022 A beat SHALL transfer only on a cycle where m_axis_tvalid and m_axis_tready are both high.
REQ-023 The grant SHALL stay on port g until a transferred beat has tlast=1. On that cycle the state SHALL return to IDLE and ptr SHALL be set to (g+1) mod N.
REQ-024 The beat counter SHALL be clog2(MAX_BEATS+1) bits wide, clear on entry to GRANT, and increment on each transfer.
REQ-025 If the MAX_BEATS-th beat transfers with tlast=0, the arbiter SHALL:
  - return to IDLE;
  - pulse trunc_error for 1 cycle;
  - advance ptr as in REQ-023.
  The remaining beats of that packet SHALL be treated as a new packet.
REQ-026 Requester valid dropping while granted SHALL NOT release the grant; the arbiter waits.
REQ-027 Valid arriving on other ports during GRANT SHALL NOT be sampled until IDLE.
REQ-028 When tlast transfers and another port is valid, that port SHALL be granted 1 cycle later. This 1-cycle idle bubble between packets is mandatory.
REQ-029 busy SHALL equal (state == GRANT), and grant SHALL equal the registered one-hot grant.
REQ-030 m_axis_tid SHALL be 0 in IDLE.

Reset
REQ-031 While rst is high, the following SHALL be forced: state IDLE, grant 0, ptr 0, beat counter 0, busy 0, trunc_error 0, s_axis_tready 0, m_axis_tvalid 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no further beats transferred. After release, arbitration SHALL restart from port 0.

Verification
REQ-033 Single port 2, 3-byte packet 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready=1 -> grant=0100 one cycle after valid, three transfers with tid=2, then busy=0 and ptr=3.
REQ-034 Ports 0 and 3 valid simultaneously from reset -> port 0 served first; after its tlast, one idle cycle, then port 3 granted.
REQ-035 All 4 ports continuously valid with 1-byte packets -> grant order 0,1,2,3,0, each separated by one idle cycle.
REQ-036 m_axis_tready held low for 10 cycles mid-packet -> no transfers, grant held, data stable; resumes when ready rises.
REQ-037 MAX_BEATS=4, port 1 sends 6 beats with tlast only on beat 6 -> trunc_error pulses after beat 4, then port 1 re-granted for beats 5-6.
REQ-038 rst pulsed after beat 2 of a 5-beat packet -> all outputs zero during reset, no further beats, next grant chosen from ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter stream from N requesters.
// A port keeps the grant until tlast transfers or MAX_BEATS beats have gone out.
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N-1:0]            s_axis_tvalid,
  input  logic [N-1:0]            s_axis_tlast,
  output logic [N-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(N)-1:0]    m_axis_tid,
  output logic [N-1:0]            grant,
  output logic                    busy,
  output logic                    trunc_error
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N-1:0]          r_grant;
  logic [N-1:0]          w_grant_nxt;
  logic [IDX_W-1:0]      r_gidx;
  logic [IDX_W-1:0]      w_gidx_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [CNT_W-1:0]      r_beats;
  logic [CNT_W-1:0]      w_beats_nxt;
  logic                  r_trunc;
  logic                  w_trunc_nxt;

  logic [DATA_WIDTH-1:0] w_port_data [N];
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_gidx_inc;
  logic                  w_found;
  logic                  w_active;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_cap;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First valid port at or after r_ptr, wrapping modulo N.
  always_comb begin
    logic [IDX_W-1:0] j;
    j         = '0;
    w_found   = 1'b0;
    w_sel_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(r_ptr) + k) % N);
      if (!w_found && s_axis_tvalid[j]) begin
        w_found   = 1'b1;
        w_sel_idx = j;
      end
    end
  end

  // Reset gates the datapath immediately so nothing transfers during the reset cycle.
  assign w_active   = (r_state == GRANT) && !rst;
  assign w_xfer     = w_active && s_axis_tvalid[r_gidx] && m_axis_tready;
  assign w_last     = s_axis_tlast[r_gidx];
  assign w_cap      = w_xfer && !w_last && (r_beats == CNT_W'(MAX_BEATS - 1));
  assign w_gidx_inc = (r_gidx == IDX_W'(N - 1)) ? '0 : r_gidx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_beats_nxt = r_beats;
    w_trunc_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_sel_idx;
          w_gidx_nxt  = w_sel_idx;
          w_beats_nxt = '0;
        end
      end
      GRANT: begin
        if (w_xfer) begin
          w_beats_nxt = r_beats + 1'b1;
          if (w_last || w_cap) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_gidx_inc;
            w_trunc_nxt = w_cap;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beats <= w_beats_nxt;
      r_trunc <= w_trunc_nxt;
    end
  end

  assign busy          = w_active;
  assign grant         = rst ? '0 : r_grant;
  assign trunc_error   = r_trunc && !rst;
  assign m_axis_tvalid = w_active && s_axis_tvalid[r_gidx];
  assign m_axis_tdata  = w_active ? w_port_data[r_gidx] : '0;
  assign m_axis_tid    = w_active ? r_gidx : '0;
  assign s_axis_tready = w_active ? (r_grant & {N{m_axis_tready}}) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=4, 8-bit, MAX_BEATS=4).
// All outputs are packed into one observation word and compared against hand-built values.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] dat;
  logic [3:0]  vld;
  logic [3:0]  lst;
  logic [3:0]  s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        mready;
  logic [1:0]  m_axis_tid;
  logic [3:0]  grant;
  logic        busy;
  logic        trunc_error;

  int total;
  int bad;

  // {grant, busy, tvalid, tid, tdata, tready, trunc_error}
  logic [20:0] obs;
  logic [20:0] exp_v;
  assign obs = {grant, busy, m_axis_tvalid, m_axis_tid, m_axis_tdata, s_axis_tready, trunc_error};

  uart_tx_arbiter #(.N(4), .DATA_WIDTH(8), .MAX_BEATS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (dat),
    .s_axis_tvalid (vld),
    .s_axis_tlast  (lst),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (mready),
    .m_axis_tid    (m_axis_tid),
    .grant         (grant),
    .busy          (busy),
    .trunc_error   (trunc_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic l, input logic [7:0] d);
    vld[p]       = v;
    lst[p]       = l;
    dat[p*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    lst = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    mready = 1'b1;
    vld    = 4'b1111;
    lst    = 4'b1111;
    dat    = 32'hD3C2B1A0;
    tick();
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL reset_forced got=%h want=%h", obs, 21'd0); end
    total++;
    tick();
    if (obs !== 21'd0) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, 21'd0); end
    total++;
    vld = '0;
    lst = '0;
    rst = 1'b0;
    tick();
    if (obs !== 21'd0) begin bad++; $display("FAIL reset_release_idle got=%h want=%h", obs, 21'd0); end
    total++;
  endtask

  task automatic test_single();
    set_port(2, 1'b1, 1'b0, 8'h41);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL single_latency got=%h want=%h", obs, 21'd0); end
    total++;
    tick();
    exp_v = {4'b0100, 1'b1, 1'b1, 2'd2, 8'h41, 4'b0100, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL single_beat1 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(2, 1'b1, 1'b0, 8'h42);
    #1;
    exp_v = {4'b0100, 1'b1, 1'b1, 2'd2, 8'h42, 4'b0100, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL single_beat2 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(2, 1'b1, 1'b1, 8'h43);
    #1;
    exp_v = {4'b0100, 1'b1, 1'b1, 2'd2, 8'h43, 4'b0100, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL single_beat3 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(2, 1'b0, 1'b0, 8'h00);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL single_release got=%h want=%h", obs, 21'd0); end
    total++;
    // ptr is now 3: with ports 0 and 3 both valid, port 3 must win.
    set_port(0, 1'b1, 1'b1, 8'h01);
    set_port(3, 1'b1, 1'b1, 8'h03);
    #1;
    tick();
    exp_v = {4'b1000, 1'b1, 1'b1, 2'd3, 8'h03, 4'b1000, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL single_ptr3 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(3, 1'b0, 1'b0, 8'h00);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL single_wrap_bubble got=%h want=%h", obs, 21'd0); end
    total++;
    tick();
    exp_v = {4'b0001, 1'b1, 1'b1, 2'd0, 8'h01, 4'b0001, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL single_wrap_port0 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(0, 1'b0, 1'b0, 8'h00);
    #1;
  endtask

  task automatic test_two_ports();
    do_reset();
    set_port(0, 1'b1, 1'b0, 8'h10);
    set_port(3, 1'b1, 1'b1, 8'h30);
    #1;
    tick();
    exp_v = {4'b0001, 1'b1, 1'b1, 2'd0, 8'h10, 4'b0001, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL two_port0_first got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(0, 1'b1, 1'b1, 8'h11);
    #1;
    exp_v = {4'b0001, 1'b1, 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL two_port0_last got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(0, 1'b0, 1'b0, 8'h00);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL two_bubble got=%h want=%h", obs, 21'd0); end
    total++;
    tick();
    exp_v = {4'b1000, 1'b1, 1'b1, 2'd3, 8'h30, 4'b1000, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL two_port3_next got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(3, 1'b0, 1'b0, 8'h00);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL two_done got=%h want=%h", obs, 21'd0); end
    total++;
  endtask

  task automatic test_round_robin();
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    #1;
    for (int k = 0; k < 5; k++) begin
      if (obs !== 21'd0) begin bad++; $display("FAIL rr_bubble_%0d got=%h want=%h", k, obs, 21'd0); end
      total++;
      tick();
      oh    = 4'b0001 << order[k];
      exp_v = {oh, 1'b1, 1'b1, 2'(order[k]), 8'(8'hA0 + order[k]), oh, 1'b0};
      if (obs !== exp_v) begin bad++; $display("FAIL rr_grant_%0d got=%h want=%h", k, obs, exp_v); end
      total++;
      tick();
    end
    vld = '0;
    lst = '0;
    #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_port(1, 1'b1, 1'b0, 8'h55);
    #1;
    tick();
    exp_v = {4'b0010, 1'b1, 1'b1, 2'd1, 8'h55, 4'b0010, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL bp_first got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(1, 1'b1, 1'b0, 8'h66);
    mready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      exp_v = {4'b0010, 1'b1, 1'b1, 2'd1, 8'h66, 4'b0000, 1'b0};
      if (obs !== exp_v) begin bad++; $display("FAIL bp_hold_%0d got=%h want=%h", c, obs, exp_v); end
      total++;
      tick();
    end
    mready = 1'b1;
    set_port(1, 1'b1, 1'b1, 8'h66);
    #1;
    exp_v = {4'b0010, 1'b1, 1'b1, 2'd1, 8'h66, 4'b0010, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL bp_resume got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(1, 1'b0, 1'b0, 8'h00);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL bp_done got=%h want=%h", obs, 21'd0); end
    total++;
  endtask

  task automatic test_truncation();
    do_reset();
    set_port(1, 1'b1, 1'b0, 8'hB1);
    #1;
    tick();
    for (int b = 1; b <= 4; b++) begin
      set_port(1, 1'b1, 1'b0, 8'(8'hB0 + b));
      #1;
      exp_v = {4'b0010, 1'b1, 1'b1, 2'd1, 8'(8'hB0 + b), 4'b0010, 1'b0};
      if (obs !== exp_v) begin bad++; $display("FAIL trunc_beat%0d got=%h want=%h", b, obs, exp_v); end
      total++;
      tick();
    end
    set_port(1, 1'b1, 1'b0, 8'hB5);
    #1;
    exp_v = {4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1};
    if (obs !== exp_v) begin bad++; $display("FAIL trunc_pulse got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    exp_v = {4'b0010, 1'b1, 1'b1, 2'd1, 8'hB5, 4'b0010, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL trunc_regrant got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(1, 1'b1, 1'b1, 8'hB6);
    #1;
    exp_v = {4'b0010, 1'b1, 1'b1, 2'd1, 8'hB6, 4'b0010, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL trunc_beat6 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(1, 1'b0, 1'b0, 8'h00);
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL trunc_normal_end got=%h want=%h", obs, 21'd0); end
    total++;
  endtask

  // Entered with ptr=2 left over from the previous packet.
  task automatic test_reset_mid();
    set_port(2, 1'b1, 1'b0, 8'hC1);
    #1;
    tick();
    exp_v = {4'b0100, 1'b1, 1'b1, 2'd2, 8'hC1, 4'b0100, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL rstmid_beat1 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(2, 1'b1, 1'b0, 8'hC2);
    #1;
    exp_v = {4'b0100, 1'b1, 1'b1, 2'd2, 8'hC2, 4'b0100, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL rstmid_beat2 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    set_port(2, 1'b1, 1'b0, 8'hC3);
    set_port(0, 1'b1, 1'b1, 8'hD0);
    rst = 1'b1;
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL rstmid_forced got=%h want=%h", obs, 21'd0); end
    total++;
    tick();
    if (obs !== 21'd0) begin bad++; $display("FAIL rstmid_held got=%h want=%h", obs, 21'd0); end
    total++;
    rst = 1'b0;
    #1;
    if (obs !== 21'd0) begin bad++; $display("FAIL rstmid_release got=%h want=%h", obs, 21'd0); end
    total++;
    tick();
    exp_v = {4'b0001, 1'b1, 1'b1, 2'd0, 8'hD0, 4'b0001, 1'b0};
    if (obs !== exp_v) begin bad++; $display("FAIL rstmid_restart_port0 got=%h want=%h", obs, exp_v); end
    total++;
    tick();
    vld = '0;
    lst = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    mready = 1'b1;
    vld    = '0;
    lst    = '0;
    dat    = '0;
    total  = 0;
    bad    = 0;
    test_reset();
    test_single();
    test_two_ports();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
